priority_grant_reg: RTL and testbench

- Parametrised, registered successor to the single-input if/else-if decision block.
- Generalises the priority chain to N request channels.
- Adds a mode select between fixed priority and round-robin, with grant hold, explicit release and a max-hold timeout.
- Sits between multiple requesters and one shared resource; all outputs are registered.

---
 rtl/priority_grant_reg.sv | 126 ++++++++++++
 tb/tb_priority_grant_reg.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/priority_grant_reg.sv
// priority_grant_reg
//   Registered N-channel arbiter for one shared resource. It selects either the
//   lowest requesting index (fixed priority) or the next requester after a
//   rotating pointer (round-robin). A grant is held until the holder releases it,
//   drops its request, or exceeds MAX_HOLD cycles. At least one idle cycle
//   always separates consecutive grants.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_req[N]       request vector, bit i = channel i requesting
//   i_release      holder finished (one-cycle pulse, ignored while idle)
//   i_mode         0 = fixed priority, 1 = round-robin (sampled while idle)
//   o_grant[N]     one-hot grant
//   o_grant_id     binary index of the granted channel
//   o_grant_valid  a grant is active
//   o_timeout      one-cycle pulse when a grant is revoked by MAX_HOLD alone
//
// Parameter constraints: 2 <= N <= 16, 2**IDW >= N, 2**HW > MAX_HOLD
// (MAX_HOLD = 0 disables the timeout).
module priority_grant_reg #(
  parameter int unsigned N        = 4,
  parameter int unsigned IDW      = 2,
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned HW       = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [N-1:0]   i_req,
  input  logic           i_release,
  input  logic           i_mode,
  output logic [N-1:0]   o_grant,
  output logic [IDW-1:0] o_grant_id,
  output logic           o_grant_valid,
  output logic           o_timeout
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);

  state_t         r_state;
  logic [N-1:0]   r_grant;
  logic [IDW-1:0] r_grant_id;
  logic           r_grant_valid;
  logic           r_timeout;
  logic [IDW-1:0] r_ptr;
  logic [HW-1:0]  r_hcnt;

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_vec;
  logic           w_found;
  logic [IDW-1:0] w_win;
  logic           w_drop;
  logic           w_hold_end;
  logic           w_exit;

  // Round-robin reuses the fixed-priority scan on a copy of the request
  // vector rotated right by the pointer; the found offset is then mapped
  // back to a channel index modulo N (N need not be a power of two).
  always_comb begin
    int unsigned j;
    int unsigned s;
    w_dbl   = {i_req, i_req};
    w_vec   = i_mode ? N'(w_dbl >> r_ptr) : i_req;
    w_found = 1'b0;
    j       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_found && ((w_vec >> i) & N'(1)) != '0) begin
        w_found = 1'b1;
        j       = i;
      end
    end
    s = i_mode ? (32'(r_ptr) + j) : j;
    if (s >= N) s = s - N;
    w_win = IDW'(s);
  end

  // Grant is one-hot, so masking with it selects the holder's request bit.
  assign w_drop     = ~|(i_req & r_grant);
  assign w_hold_end = (MAX_HOLD != 0) && (r_hcnt == HOLD_LAST);
  assign w_exit     = i_release | w_drop | w_hold_end;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
      r_ptr         <= '0;
      r_hcnt        <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state       <= S_GRANT;
            r_grant       <= N'(1) << w_win;
            r_grant_id    <= w_win;
            r_grant_valid <= 1'b1;
            r_hcnt        <= '0;
            if (i_mode) r_ptr <= (w_win == IDW'(N - 1)) ? '0 : w_win + IDW'(1);
          end
        end
        S_GRANT: begin
          r_hcnt <= r_hcnt + HW'(1);
          if (w_exit) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= w_hold_end & ~i_release & ~w_drop;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_id    = r_grant_id;
  assign o_grant_valid = r_grant_valid;
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_priority_grant_reg.sv
module tb_priority_grant_reg;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       rel;
  logic       mode;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;
  logic       timeout;

  priority_grant_reg #(.N(4), .IDW(2), .MAX_HOLD(15), .HW(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .i_release    (rel),
    .i_mode       (mode),
    .o_grant      (grant),
    .o_grant_id   (grant_id),
    .o_grant_valid(grant_valid),
    .o_timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic [1:0] id;
    logic       v;
    logic       to;
    int         tag;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_step  = 0;

  // Monitor: outputs settle after each rising edge; compare them with the
  // oldest outstanding expectation.
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_total++;
        if (grant === e.g && grant_id === e.id && grant_valid === e.v && timeout === e.to)
          n_pass++;
        else
          $display("FAIL step%0d: got grant=%b id=%0d valid=%b timeout=%b, want grant=%b id=%0d valid=%b timeout=%b",
                   e.tag, grant, grant_id, grant_valid, timeout, e.g, e.id, e.v, e.to);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic [3:0] r, input logic rl, input logic m,
                      input logic ev, input logic [1:0] eid, input logic eto);
    exp_t e;
    @(negedge clk);
    req  = r;
    rel  = rl;
    mode = m;
    n_step++;
    e.g   = ev ? (4'b0001 << eid) : 4'b0000;
    e.id  = ev ? eid : 2'd0;
    e.v   = ev;
    e.to  = eto;
    e.tag = n_step;
    q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    n_total++;
    if (grant === 4'b0 && grant_id === 2'd0 && grant_valid === 1'b0 && timeout === 1'b0)
      n_pass++;
    else
      $display("FAIL %s: got grant=%b id=%0d valid=%b timeout=%b, want all zero",
               name, grant, grant_id, grant_valid, timeout);
  endtask

  task automatic drain();
    int budget;
    budget = 50;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #3;
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations still pending, want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    rel   = 1'b0;
    mode  = 1'b0;
    #2;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed priority: lowest index wins, release, then re-grant after one idle cycle.
    step(4'b0110, 0, 0, 1, 2'd1, 0);
    step(4'b0110, 1, 0, 0, 2'd0, 0);
    step(4'b0110, 0, 0, 1, 2'd1, 0);
    step(4'b0110, 1, 0, 0, 2'd0, 0);
    step(4'b1100, 0, 0, 1, 2'd2, 0);
    step(4'b1110, 0, 0, 1, 2'd2, 0);   // other req bits ignored while held
    step(4'b0000, 0, 0, 0, 2'd0, 0);   // requester dropped
    step(4'b0000, 1, 0, 0, 2'd0, 0);   // release ignored while idle

    // Round-robin over all four channels: 0,1,2,3,0.
    step(4'b1111, 0, 1, 1, 2'd0, 0);
    step(4'b1111, 1, 1, 0, 2'd0, 0);
    step(4'b1111, 0, 1, 1, 2'd1, 0);
    step(4'b1111, 1, 0, 0, 2'd0, 0);   // mode change during grant ignored
    step(4'b1111, 0, 1, 1, 2'd2, 0);
    step(4'b1111, 1, 1, 0, 2'd0, 0);
    step(4'b1111, 0, 1, 1, 2'd3, 0);
    step(4'b1111, 1, 1, 0, 2'd0, 0);
    step(4'b1111, 0, 1, 1, 2'd0, 0);
    step(4'b1111, 1, 1, 0, 2'd0, 0);

    // Pointer now 1: grant ch2 (ptr->3), then wrap to ch0 (ptr->1), then ch1.
    step(4'b0100, 0, 1, 1, 2'd2, 0);
    step(4'b0100, 1, 1, 0, 2'd0, 0);
    step(4'b0011, 0, 1, 1, 2'd0, 0);
    step(4'b0011, 1, 1, 0, 2'd0, 0);
    step(4'b0011, 0, 1, 1, 2'd1, 0);
    step(4'b0011, 1, 1, 0, 2'd0, 0);

    // Timeout: ch2 held alone for exactly 15 cycles, then pulse, then re-grant.
    for (int i = 0; i < 15; i++) step(4'b0100, 0, 0, 1, 2'd2, 0);
    step(4'b0100, 0, 0, 0, 2'd0, 1);
    step(4'b0100, 0, 0, 1, 2'd2, 0);
    step(4'b0100, 1, 0, 0, 2'd0, 0);

    // Release coinciding with the last hold cycle: no timeout pulse.
    for (int i = 0; i < 15; i++) step(4'b0010, 0, 0, 1, 2'd1, 0);
    step(4'b0010, 1, 0, 0, 2'd0, 0);
    step(4'b0010, 0, 0, 1, 2'd1, 0);
    step(4'b0000, 0, 0, 0, 2'd0, 0);

    // Requester drop on ch3, then re-grant ch3 for the reset test.
    step(4'b1000, 0, 0, 1, 2'd3, 0);
    step(4'b0000, 0, 0, 0, 2'd0, 0);
    step(4'b1000, 0, 0, 1, 2'd3, 0);
    step(4'b1000, 0, 0, 1, 2'd3, 0);
    drain();

    // Asynchronous reset mid-grant: outputs clear before the next edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    req   = '0;
    rst_n = 1'b1;

    // Pointer was 2 before reset; after reset it must be 0, so ch0 wins.
    step(4'b1111, 0, 1, 1, 2'd0, 0);
    step(4'b1111, 1, 1, 0, 2'd0, 0);
    step(4'b1111, 0, 1, 1, 2'd1, 0);
    step(4'b0000, 0, 1, 0, 2'd0, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
